// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch PC, IMEM address, prefetch FIFO and decode handshake
module ifetch_unit #(
  parameter int DEPTH = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_instr,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        instr_ready
);
  localparam int AW = $clog2(DEPTH);
  logic [15:0] fetch_pc;
  logic [AW:0] count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [15:0] mem_instr [DEPTH];
  logic [15:0] mem_pc [DEPTH];
  logic push, pop;
  assign imem_addr = fetch_pc;
  assign instr_valid = (count != '0) & !redirect_valid;
  assign instr = mem_instr[rd_ptr];
  assign instr_pc = mem_pc[rd_ptr];
  assign pop = instr_valid & instr_ready;
  assign push = !halt & !redirect_valid & ((count < (AW+1)'(DEPTH)) | pop);
  // fetch pc, fifo pointers/count and storage; redirect flushes and wins over push/pop
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fetch_pc <= RESET_PC;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i] <= '0;
      end
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= imem_instr;
        mem_pc[wr_ptr] <= fetch_pc;
        wr_ptr <= wr_ptr + AW'(1);
        fetch_pc <= fetch_pc + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= (push & !pop) ? count + (AW+1)'(1) : (pop & !push) ? count - (AW+1)'(1) : count;
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: random and directed stimulus checked against a queue model of the fetch stream
module tb_ifetch_unit;
  localparam int DEPTH = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;
  logic clk = 0, rst = 1;
  logic [15:0] imem_addr, imem_instr, redirect_pc = 0, instr, instr_pc;
  logic halt = 0, redirect_valid = 0, instr_valid, instr_ready = 0;
  int checks = 0, errors = 0;
  logic [31:0] q [$];
  logic [15:0] mpc;
  ifetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .halt(halt), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );
  always #5 clk = ~clk;
  assign imem_instr = 16'hA000 + imem_addr;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cycle(input logic h, input logic rv, input logic [15:0] rpc, input logic rdy);
    logic ev, mpop, mpush;
    @(negedge clk);
    halt = h; redirect_valid = rv; redirect_pc = rpc; instr_ready = rdy;
    #1;
    ev = (q.size() != 0) && !rv;
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, ev});
    chk("imem_addr", {16'd0, imem_addr}, {16'd0, mpc});
    if (ev) begin
      chk("instr", {16'd0, instr}, {16'd0, q[0][15:0]});
      chk("instr_pc", {16'd0, instr_pc}, {16'd0, q[0][31:16]});
    end
    mpop = ev && rdy;
    mpush = !h && !rv && (q.size() < DEPTH || mpop);
    @(posedge clk);
    if (rv) begin
      q.delete();
      mpc = rpc;
    end else begin
      if (mpop) void'(q.pop_front());
      if (mpush) begin
        q.push_back({mpc, mpc + 16'hA000});
        mpc = mpc + 16'd1;
      end
    end
  endtask
  initial begin
    logic [15:0] rpc;
    mpc = RESET_PC;
    #12;
    chk("rst_valid", {31'd0, instr_valid}, 0);
    chk("rst_instr", {16'd0, instr}, 0);
    chk("rst_pc", {16'd0, instr_pc}, 0);
    chk("rst_addr", {16'd0, imem_addr}, {16'd0, RESET_PC});
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
    cycle(0, 1, 16'h0040, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1);
    cycle(0, 1, 16'hFFFF, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1);
    cycle(0, 1, 16'h0100, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 1);
    cycle(1, 1, 16'h0200, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1);
    cycle(0, 1, 16'h0300, 1);
    cycle(0, 1, 16'h0310, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      rpc = ($urandom_range(1) == 0) ? 16'hFFFC + 16'($urandom_range(3)) : 16'($urandom);
      cycle($urandom_range(3) == 0, $urandom_range(9) == 0, rpc, $urandom_range(3) != 0);
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    @(negedge clk);
    halt = 0; redirect_valid = 0; instr_ready = 1;
    #2 rst = 1;
    #1;
    chk("async_valid", {31'd0, instr_valid}, 0);
    chk("async_addr", {16'd0, imem_addr}, {16'd0, RESET_PC});
    q.delete();
    mpc = RESET_PC;
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
